// File: rtl/debug_uart_pkg.sv
// Shared constants for the debug UART arbiter: FSM encoding, grant encoding, line rate.
package debug_uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  localparam logic GRANT_CPU   = 1'b0;
  localparam logic GRANT_TRACE = 1'b1;

  localparam int unsigned DEBUG_UART_BIT_RATE = 1_000_000;

endpackage

// File: rtl/debug_uart_arbiter_byte_fifo.sv
// Synchronous byte FIFO with occupancy counter; the counter alone decides full/empty.
module byte_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LEVEL_W = 3
) (
  input  logic               clk,
  input  logic               rst_reg_n,
  input  logic               push,
  input  logic [7:0]         din,
  input  logic               pop,
  output logic [7:0]         dout,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LEVEL_W-1:0] count_q;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == LEVEL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a write while full is still accepted.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_q];
  assign level   = count_q;

  always_ff @(posedge clk or negedge rst_reg_n) begin
    if (!rst_reg_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LEVEL_W'(1);
        2'b01:   count_q <= count_q - LEVEL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/debug_uart_arbiter.sv
// Shares the debug uart_tx between buffered CPU writes and the trace source, round-robin.
module debug_uart_arbiter
  import debug_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEVEL_W    = 3
) (
  input  logic               clk,
  input  logic               rst_reg_n,
  input  logic               cpu_wr,
  input  logic [7:0]         cpu_data,
  input  logic               cpu_clr_ovf,
  input  logic               trace_req,
  input  logic [7:0]         trace_data,
  output logic               trace_ack,
  output logic               uart_tx_en,
  output logic [7:0]         uart_tx_data,
  input  logic               uart_tx_busy,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               fifo_full,
  output logic               ovf,
  output logic               busy
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       last_grant_q;
  logic [7:0] tx_data_q;
  logic       tx_en_q;
  logic       ack_q;
  logic       ovf_q;
  logic       grant_cpu;
  logic       grant_trace;
  logic       fifo_empty;
  logic [7:0] fifo_dout;

  byte_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_reg_n (rst_reg_n),
    .push      (cpu_wr),
    .din       (cpu_data),
    .pop       (grant_cpu),
    .dout      (fifo_dout),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    grant_cpu   = 1'b0;
    grant_trace = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!uart_tx_busy) begin
          if (!fifo_empty && (!trace_req || last_grant_q == GRANT_TRACE)) begin
            grant_cpu = 1'b1;
          end else if (trace_req) begin
            grant_trace = 1'b1;
          end
        end
        if (grant_cpu || grant_trace) state_d = ST_SEND;
      end
      ST_SEND:  state_d = ST_GUARD;
      // uart_tx raises busy a cycle late, so it is not trusted here.
      ST_GUARD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!uart_tx_busy) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_reg_n) begin
    if (!rst_reg_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_TRACE;
      tx_data_q    <= 8'h00;
      tx_en_q      <= 1'b0;
      ack_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_en_q <= grant_cpu || grant_trace;
      ack_q   <= grant_trace;
      if (grant_cpu) begin
        tx_data_q    <= fifo_dout;
        last_grant_q <= GRANT_CPU;
      end else if (grant_trace) begin
        tx_data_q    <= trace_data;
        last_grant_q <= GRANT_TRACE;
      end
      // Set beats clear when a dropped write and a clear coincide.
      if (cpu_wr && fifo_full && !grant_cpu) begin
        ovf_q <= 1'b1;
      end else if (cpu_clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign uart_tx_en   = tx_en_q;
  assign trace_ack    = ack_q;
  assign uart_tx_data = tx_data_q;
  assign ovf          = ovf_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_debug_uart_arbiter.sv
// Randomised bench for debug_uart_arbiter against a queue-based model of the arbiter rules.
module tb_debug_uart_arbiter;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst_reg_n;
  logic          cpu_wr;
  logic [7:0]    cpu_data;
  logic          cpu_clr_ovf;
  logic          trace_req;
  logic [7:0]    trace_data;
  logic          trace_ack;
  logic          uart_tx_en;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_busy;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          ovf;
  logic          busy;

  always #5 clk = ~clk;

  debug_uart_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .LEVEL_W    (LW)
  ) dut (
    .clk          (clk),
    .rst_reg_n    (rst_reg_n),
    .cpu_wr       (cpu_wr),
    .cpu_data     (cpu_data),
    .cpu_clr_ovf  (cpu_clr_ovf),
    .trace_req    (trace_req),
    .trace_data   (trace_data),
    .trace_ack    (trace_ack),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .fifo_level   (fifo_level),
    .fifo_full    (fifo_full),
    .ovf          (ovf),
    .busy         (busy)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model: FIFO contents, sticky overflow, who went last, and cycles since the last grant.
  byte unsigned mq[$];
  byte unsigned m_accepted[$];
  bit           m_ovf;
  bit           m_last_trace;
  bit           m_en;
  bit           m_ack;
  int           m_age;
  logic [7:0]   m_data;

  // UART stand-in and logs.
  bit           force_busy = 0;
  int           busy_cnt   = 0;
  int           busy_len   = 20;
  byte unsigned emitted[$];
  byte unsigned cpu_emitted[$];
  int           ack_cnt = 0;
  logic [7:0]   ack_data;
  int           en_cyc = 0;
  int           wr_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf        = 0;
    m_last_trace = 1;
    m_en         = 0;
    m_ack        = 0;
    m_age        = 0;
    m_data       = 8'h00;
  endtask

  // Applies one clock edge worth of the arbiter rules to the model.
  task automatic model_advance();
    bit popped;
    bit was_full;
    popped   = 0;
    was_full = (mq.size() == DEPTH);
    m_en     = 0;
    m_ack    = 0;
    if (m_age == 0) begin
      if (!uart_tx_busy) begin
        if (mq.size() > 0 && (!trace_req || m_last_trace)) begin
          m_data       = mq.pop_front();
          popped       = 1;
          m_last_trace = 0;
          m_age        = 1;
          m_en         = 1;
        end else if (trace_req) begin
          m_data       = trace_data;
          m_last_trace = 1;
          m_age        = 1;
          m_en         = 1;
          m_ack        = 1;
        end
      end
    end else if (m_age >= 3) begin
      if (!uart_tx_busy) m_age = 0;
    end else begin
      m_age++;
    end
    if (cpu_clr_ovf) m_ovf = 0;
    if (cpu_wr) begin
      if (!was_full || popped) begin
        mq.push_back(cpu_data);
        m_accepted.push_back(cpu_data);
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  // One clock: advance the model, compare every output, then update the UART stand-in.
  task automatic step();
    @(negedge clk);
    if (!rst_reg_n) model_reset();
    else model_advance();
    cyc++;
    chk("uart_tx_en",   uart_tx_en,   m_en);
    chk("trace_ack",    trace_ack,    m_ack);
    chk("uart_tx_data", uart_tx_data, m_data);
    chk("fifo_level",   fifo_level,   mq.size());
    chk("fifo_full",    fifo_full,    mq.size() == DEPTH);
    chk("ovf",          ovf,          m_ovf);
    chk("busy",         busy,         (m_age != 0) || (mq.size() > 0));
    if (uart_tx_en === 1'b1) begin
      emitted.push_back(uart_tx_data);
      if (trace_ack !== 1'b1) cpu_emitted.push_back(uart_tx_data);
      en_cyc = cyc;
    end
    if (trace_ack === 1'b1) begin
      ack_cnt++;
      ack_data  = uart_tx_data;
      trace_req = 1'b0;
    end
    uart_tx_busy = force_busy || (busy_cnt > 0);
    if (uart_tx_en === 1'b1) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((busy !== 1'b0 || busy_cnt > 0 || uart_tx_busy) && n < lim) begin
      step();
      n++;
    end
    chk("wait_idle_bound", n < lim, 1);
  endtask

  task automatic wait_emits(input int count, input int lim);
    int n;
    n = 0;
    while (emitted.size() < count && n < lim) begin
      step();
      n++;
    end
    chk("wait_emit_bound", emitted.size() >= count, 1);
  endtask

  task automatic write_byte(input logic [7:0] b);
    cpu_wr   = 1'b1;
    cpu_data = b;
    step();
    cpu_wr   = 1'b0;
  endtask

  task automatic rand_trace();
    if (!trace_req && $urandom_range(0, 7) == 0) begin
      trace_data = 8'($urandom);
      trace_req  = 1'b1;
    end else if (trace_req && $urandom_range(0, 15) == 0) begin
      trace_req = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_reg_n    = 1'b0;
    cpu_wr       = 1'b0;
    cpu_data     = 8'h00;
    cpu_clr_ovf  = 1'b0;
    trace_req    = 1'b0;
    trace_data   = 8'h00;
    uart_tx_busy = 1'b0;
    model_reset();

    repeat (3) step();
    chk("reset_level", fifo_level, 0);
    chk("reset_en",    uart_tx_en, 0);
    chk("reset_busy",  busy, 0);
    chk("reset_data",  uart_tx_data, 0);
    rst_reg_n = 1'b1;
    while (cyc < 10) step();

    // Single CPU byte: en two cycles after the write.
    emitted.delete();
    wr_cyc = cyc;
    write_byte(8'h41);
    wait_emits(1, 10);
    chk("t1_latency", en_cyc - wr_cyc, 2);
    chk("t1_data", emitted[0], 8'h41);
    chk("t1_busy", busy, 1);
    wait_idle(100);

    // Overflow while the UART is held busy, then drain in order.
    emitted.delete();
    force_busy = 1;
    step();
    for (int i = 0; i < 5; i++) write_byte(8'(8'h10 + i));
    chk("t2_level", fifo_level, 4);
    chk("t2_full", fifo_full, 1);
    chk("t2_ovf_set", ovf, 1);
    cpu_clr_ovf = 1'b1;
    step();
    cpu_clr_ovf = 1'b0;
    chk("t2_ovf_clr", ovf, 0);
    force_busy = 0;
    wait_emits(4, 200);
    for (int i = 0; i < 4; i++) chk("t2_order", emitted[i], 8'(8'h10 + i));
    wait_idle(200);

    // Trace alone; dropped on ack, so exactly one send.
    emitted.delete();
    ack_cnt    = 0;
    trace_data = 8'h7E;
    trace_req  = 1'b1;
    wait_emits(1, 10);
    repeat (40) step();
    chk("t4_count", emitted.size(), 1);
    chk("t4_data", emitted[0], 8'h7E);
    chk("t4_acks", ack_cnt, 1);
    wait_idle(100);

    // CPU and trace both pending: strict alternation, CPU first after a trace grant.
    emitted.delete();
    ack_cnt    = 0;
    force_busy = 1;
    write_byte(8'hA0);
    write_byte(8'hA1);
    trace_data = 8'h55;
    trace_req  = 1'b1;
    force_busy = 0;
    wait_emits(3, 200);
    chk("t3_first", emitted[0], 8'hA0);
    chk("t3_second", emitted[1], 8'h55);
    chk("t3_third", emitted[2], 8'hA1);
    wait_idle(200);
    chk("t3_acks", ack_cnt, 1);
    chk("t3_ack_data", ack_data, 8'h55);

    // Write while full coinciding with a pop.
    emitted.delete();
    force_busy = 1;
    step();
    for (int i = 0; i < 4; i++) write_byte(8'(8'hC0 + i));
    chk("t5_level_full", fifo_level, 4);
    force_busy = 0;
    step();
    write_byte(8'hC4);
    chk("t5_level_kept", fifo_level, 4);
    chk("t5_no_ovf", ovf, 0);
    wait_emits(5, 300);
    for (int i = 0; i < 5; i++) chk("t5_order", emitted[i], 8'(8'hC0 + i));
    wait_idle(200);

    // Random burst with random trace traffic and UART busy times.
    cpu_emitted.delete();
    m_accepted.delete();
    for (int i = 0; i < 100; i++) begin
      int gap;
      gap = $urandom_range(0, 8);
      for (int g = 0; g < gap; g++) begin
        rand_trace();
        cpu_clr_ovf = ($urandom_range(0, 19) == 0);
        step();
        cpu_clr_ovf = 1'b0;
      end
      busy_len = $urandom_range(1, 6);
      rand_trace();
      write_byte(8'($urandom));
    end
    trace_req = 1'b0;
    wait_idle(1000);
    chk("burst_count", cpu_emitted.size(), m_accepted.size());
    for (int i = 0; i < cpu_emitted.size() && i < m_accepted.size(); i++) begin
      chk("burst_order", cpu_emitted[i], m_accepted[i]);
    end

    // Asynchronous reset in WAIT with bytes still queued.
    busy_len = 20;
    emitted.delete();
    write_byte(8'hB0);
    write_byte(8'hB1);
    write_byte(8'hB2);
    step();
    step();
    chk("t6_pending", fifo_level, 2);
    #2;
    rst_reg_n = 1'b0;
    #1;
    chk("t6_en", uart_tx_en, 0);
    chk("t6_ack", trace_ack, 0);
    chk("t6_data", uart_tx_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_full", fifo_full, 0);
    chk("t6_ovf", ovf, 0);
    model_reset();
    step();
    rst_reg_n = 1'b1;
    repeat (30) step();
    chk("t6_level_after", fifo_level, 0);
    chk("t6_no_send", emitted.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/debug_uart_arbiter.md
Name: debug_uart_arbiter

Overview:
- Shares the single debug UART transmitter (1 Mbaud `uart_tx` instance in the top level) between two requesters:
  - CPU byte writes to the debug UART address, buffered in a small FIFO.
  - A hardware trace source that streams register-write debug bytes.
- Sequences `uart_tx_en` against `uart_tx_busy`, arbitrates round-robin, and reports FIFO level and overflow status.
- Sits between the peripheral address decode and `uart_tx`.

Parameters:
- FIFO_DEPTH, 4, CPU byte FIFO entries; power of two, minimum 2.
- LEVEL_W, 3, width of `fifo_level`; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock.
- rst_reg_n  in  1  reset: asynchronous, active-low.
- cpu_wr  in  1  one-cycle pulse; CPU write to the debug UART data address.
- cpu_data  in  8  byte to enqueue, valid with `cpu_wr`.
- cpu_clr_ovf  in  1  one-cycle pulse; clears `ovf`.
- trace_req  in  1  level; trace byte pending; held until `trace_ack`.
- trace_data  in  8  trace byte; stable while `trace_req`=1.
- trace_ack  out  1  one-cycle pulse; trace byte taken.
- uart_tx_en  out  1  one-cycle start pulse to `uart_tx`.
- uart_tx_data  out  8  byte to `uart_tx`; registered.
- uart_tx_busy  in  1  transmitter busy.
- fifo_level  out  LEVEL_W  current CPU FIFO occupancy, 0..FIFO_DEPTH.
- fifo_full  out  1  `fifo_level`==FIFO_DEPTH.
- ovf  out  1  sticky; a CPU write was dropped.
- busy  out  1  arbiter not in IDLE, or FIFO non-empty; CPU-readable status.

Behaviour:
- Reset (async, `rst_reg_n`=0):
  - FIFO pointers 0, `fifo_level`=0, `fifo_full`=0, `ovf`=0.
  - `uart_tx_en`=0, `uart_tx_data`=0, `trace_ack`=0, `busy`=0.
  - FSM=IDLE, `last_grant`=TRACE, so the CPU wins the first tie.
  - Reset mid-byte abandons the transfer; the UART finishes or resets independently.
- FIFO:
  - `cpu_wr` with `fifo_full`=0 enqueues.
  - `cpu_wr` with `fifo_full`=1 drops the byte and sets `ovf`.
  - Full plus a same-cycle pop: the write is accepted and the level is unchanged.
  - `cpu_wr` and `cpu_clr_ovf` in the same cycle while full: `ovf` stays 1 (set wins).
  - Pointers wrap modulo FIFO_DEPTH. The level counter is authoritative for full/empty.
- FSM states: IDLE, SEND, GUARD, WAIT.
- IDLE, when `uart_tx_busy`=0:
  - Grant = CPU if FIFO non-empty and (`trace_req`=0 or `last_grant`=TRACE).
  - Else grant = TRACE if `trace_req`=1.
  - Else stay in IDLE.
  - On grant: register the byte into `uart_tx_data`, update `last_grant`, go to SEND.
  - With a CPU grant, the FIFO pops in this same cycle.
- SEND:
  - `uart_tx_en`=1 for exactly this cycle.
  - `trace_ack`=1 this cycle if the grant was TRACE.
  - Go to GUARD.
- GUARD: one cycle, ignores `uart_tx_busy` to cover the UART's registered busy assertion. Go to WAIT.
- WAIT: stay while `uart_tx_busy`=1; go to IDLE when it is 0.
- Latency: with the FIFO empty, FSM in IDLE and the UART idle, `cpu_wr` at cycle N gives `uart_tx_en` at N+2.
- Minimum spacing between `uart_tx_en` pulses is 4 cycles plus the UART busy time.
- Fairness: with both requesters continuously pending, grants strictly alternate.
- `trace_req` dropped before its grant is legal; that request is simply not served.

Decomposition:
- Shared package `debug_uart_pkg` holds:
  - FSM state encoding: IDLE=2'd0, SEND=2'd1, GUARD=2'd2, WAIT=2'd3.
  - Grant encoding: CPU=1'b0, TRACE=1'b1.
  - DEBUG_UART_BIT_RATE=1_000_000.
- One sub-module: `byte_fifo`. A parameterised synchronous FIFO with push, pop, dout, level, full and empty; asynchronous reset; no bypass path.
- The arbiter FSM and registers live in the top of the block.

Test Plan:
- Reset, then `cpu_wr` with `cpu_data`=0x41 at cycle 10, `uart_tx_busy` modelled 20 cycles after en → `uart_tx_en` at cycle 12 with `uart_tx_data`=0x41; `busy`=1 until the FSM returns to IDLE.
- 5 back-to-back `cpu_wr` (0x10..0x14) while `uart_tx_busy`=1 held, FIFO_DEPTH=4:
  - 0x10..0x13 enqueue; 0x14 dropped, `fifo_full`=1, `ovf`=1.
  - `cpu_clr_ovf` → `ovf`=0.
  - Release busy → bytes emitted in order 0x10..0x13.
- FIFO holding 0xA0,0xA1 and `trace_req` held with 0x55 → emitted order 0xA0, 0x55, 0xA1; `trace_ack` pulses once, in the SEND cycle for 0x55.
- `trace_req` alone with `trace_data`=0x7E → one `uart_tx_en` with 0x7E and one `trace_ack`; no second send while `trace_req` is dropped on ack.
- Simultaneous `cpu_wr` and pop at `fifo_level`=4 → level stays 4, no `ovf`; 100-write random burst → byte order preserved across pointer wrap.
- Assert `rst_reg_n`=0 during WAIT → all outputs reset asynchronously that cycle; after release, pending FIFO contents are gone and `fifo_level`=0.
